mem_port_arbiter: RTL and testbench

- Shares a single-port 8-bit-wide RAM (DEPTH bytes) between the IF-stage instruction fetch and the MEM-stage data access.
- Serializes each word, halfword or byte access into 1-byte RAM beats.
- Returns assembled read data with a one-cycle ready pulse.
- Raises per-requester stall signals that the hazard logic uses to freeze the PC and the pipeline registers.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide single-port RAM between instruction fetch and data access; serializes words into big-endian byte beats.
// Latency N+1 cycles from grant to ready (1 for a rejected access); losing or waiting requesters see stall until their ready pulse.
module mem_port_arbiter #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [32:0] DEPTH_X = 33'(DEPTH);

  logic [1:0]        state;
  logic [1:0]        beat;
  logic              own_mem;
  logic              rw_q;
  logic              bad_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic [1:0]  last_beat;
  logic [1:0]  wr_idx;
  logic [31:0] asm_next;
  logic [2:0]  req_n;
  logic [32:0] end_addr;
  logic        req_bad;
  logic        in_access;
  logic        unused_if_hi;

  assign unused_if_hi = ^if_addr[31:ADDR_W];

  always_comb begin
    req_n = 3'd4;
    case (mem_size)
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  // Last byte of the access must also fall inside the RAM.
  assign end_addr = {1'b0, mem_addr} + 33'(req_n) - 33'd1;
  assign req_bad  = (mem_size == 2'b11)
                  | ((mem_size == 2'b01) & mem_addr[0])
                  | ((mem_size == 2'b10) & (|mem_addr[1:0]))
                  | ({1'b0, mem_addr} >= DEPTH_X)
                  | (end_addr >= DEPTH_X);

  always_comb begin
    last_beat = 2'd3;
    if (own_mem) begin
      case (size_q)
        2'b00:   last_beat = 2'd0;
        2'b01:   last_beat = 2'd1;
        default: last_beat = 2'd3;
      endcase
    end
  end

  // Clearing asm_q at grant makes byte and halfword results zero-extended.
  assign asm_next = {asm_q[23:0], ram_rdata};
  assign wr_idx   = last_beat - beat;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      beat      <= 2'd0;
      own_mem   <= 1'b0;
      rw_q      <= 1'b0;
      bad_q     <= 1'b0;
      size_q    <= 2'b00;
      base_q    <= '0;
      wdata_q   <= 32'd0;
      asm_q     <= 32'd0;
      if_rdata  <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            own_mem <= 1'b1;
            rw_q    <= mem_rw;
            size_q  <= mem_size;
            base_q  <= mem_addr[ADDR_W-1:0];
            wdata_q <= mem_wdata;
            bad_q   <= req_bad;
            beat    <= 2'd0;
            asm_q   <= 32'd0;
            state   <= req_bad ? DONE : ACCESS;
          end else if (if_req) begin
            own_mem <= 1'b0;
            rw_q    <= 1'b0;
            size_q  <= 2'b10;
            base_q  <= if_addr[ADDR_W-1:0];
            bad_q   <= 1'b0;
            beat    <= 2'd0;
            asm_q   <= 32'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!rw_q) asm_q <= asm_next;
          if (beat == last_beat) begin
            state <= DONE;
            if (!rw_q) begin
              if (own_mem) mem_rdata <= asm_next;
              else         if_rdata  <= asm_next;
            end
          end else begin
            beat <= beat + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access = (state == ACCESS);
  assign ram_addr  = in_access ? base_q + ADDR_W'(beat) : '0;
  assign ram_we    = in_access & rw_q;
  assign ram_wdata = ram_we ? wdata_q[{wr_idx, 3'b000} +: 8] : 8'd0;

  assign if_ready  = (state == DONE) & ~own_mem;
  assign mem_ready = (state == DONE) & own_mem;
  assign mem_err   = mem_ready & bad_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: a byte-array reference model predicts each completion; a negedge monitor checks them.
module tb_mem_port_arbiter;
  localparam int DEPTH = 256;
  localparam int ADDR_W = 8;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic if_ready;
  logic mem_req = 1'b0;
  logic mem_rw = 1'b0;
  logic [1:0] mem_size = 2'b00;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic mem_ready, mem_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic ram_we, stall_if, stall_mem, busy;

  mem_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .CLR(CLR),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ram [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic [15:0] wr_log [$];

  assign ram_rdata = ram[ram_addr];
  always @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      wr_log.push_back({ram_addr, ram_wdata});
    end
  end

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_mem_q [$];
  logic [31:0] exp_if_q [$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;
  logic        last_ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every ready pulse is matched against the oldest prediction.
  always @(negedge CLK) begin
    exp_t e;
    logic [31:0] f;
    if (CLR) begin
      last_rd = 32'd0;
      last_ok = 1'b1;
    end else begin
      if (if_ready) begin
        if (exp_if_q.size() == 0) chk("if_unexpected_ready", 32'd1, 32'd0);
        else begin
          f = exp_if_q.pop_front();
          chk("if_rdata", if_rdata, f);
        end
      end
      if (mem_ready) begin
        if (exp_mem_q.size() == 0) chk("mem_unexpected_ready", 32'd1, 32'd0);
        else begin
          e = exp_mem_q.pop_front();
          chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
          if (e.err) last_ok = 1'b0;
          else if (e.wr) begin
            if (last_ok) chk("mem_rdata_hold_on_write", mem_rdata, last_rd);
          end else begin
            chk("mem_rdata", mem_rdata, e.dat);
            last_rd = e.dat;
            last_ok = 1'b1;
          end
        end
      end
    end
  end

  task automatic model_mem(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output int lat);
    int n;
    longint ea;
    logic bad;
    logic [31:0] v;
    exp_t e;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea = longint'(a);
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
       || (ea >= DEPTH) || (ea + n - 1 >= DEPTH);
    v = 32'd0;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        if (rw) ref_mem[ea + i] = 8'(wd >> (8 * (n - 1 - i)));
        else    v = (v << 8) | 32'(ref_mem[ea + i]);
      end
    end
    e.wr = rw; e.err = bad; e.dat = v;
    exp_mem_q.push_back(e);
    lat = bad ? 1 : n + 1;
  endtask

  task automatic model_if(input logic [31:0] a, output int lat);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < 4; i++) v = (v << 8) | 32'(ref_mem[(a + 32'(i)) % DEPTH]);
    exp_if_q.push_back(v);
    lat = 5;
  endtask

  task automatic drive_mem(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output int lat);
    logic bad_stall;
    @(negedge CLK);
    mem_rw = rw; mem_size = sz; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    lat = 0; bad_stall = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (mem_ready) begin
        if (stall_mem) bad_stall = 1'b1;
        lat = k;
        break;
      end
      if (!stall_mem) bad_stall = 1'b1;
    end
    mem_req = 1'b0;
    if (lat == 0) chk("mem_timeout", 32'd1, 32'd0);
    chk("stall_mem_profile", {31'd0, bad_stall}, 32'd0);
  endtask

  task automatic drive_if(input logic [31:0] a, output int lat);
    logic bad_stall;
    @(negedge CLK);
    if_addr = a; if_req = 1'b1;
    lat = 0; bad_stall = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (if_ready) begin
        if (stall_if) bad_stall = 1'b1;
        lat = k;
        break;
      end
      if (!stall_if) bad_stall = 1'b1;
    end
    if_req = 1'b0;
    if (lat == 0) chk("if_timeout", 32'd1, 32'd0);
    chk("stall_if_profile", {31'd0, bad_stall}, 32'd0);
  endtask

  task automatic do_mem(input logic rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int el, lat;
    model_mem(rw, sz, a, wd, el);
    drive_mem(rw, sz, a, wd, lat);
    if (lat != 0) chk("mem_latency", 32'(lat), 32'(el));
  endtask

  task automatic do_if(input logic [31:0] a);
    int el, lat;
    model_if(a, el);
    drive_if(a, lat);
    if (lat != 0) chk("if_latency", 32'(lat), 32'(el));
  endtask

  // Both requests raised together: MEM first, IF granted on the IDLE after MEM's DONE.
  task automatic do_both(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] fa);
    int elm, eli, lm, li;
    model_mem(rw, sz, a, wd, elm);
    model_if(fa, eli);
    fork
      drive_mem(rw, sz, a, wd, lm);
      drive_if(fa, li);
    join
    if (lm != 0) chk("both_mem_latency", 32'(lm), 32'(elm));
    if (li != 0) chk("both_if_latency", 32'(li), 32'(elm + 1 + eli));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    logic [15:0] exp_log [4];
    logic [31:0] a, wd;
    logic [1:0] sz;
    logic [15:0] ent;
    int mism;

    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram[0] <= 8'hE3; ram[1] <= 8'hA0; ram[2] <= 8'h10; ram[3] <= 8'h05;
    ref_mem[0] = 8'hE3; ref_mem[1] = 8'hA0; ref_mem[2] = 8'h10; ref_mem[3] = 8'h05;

    repeat (3) @(negedge CLK);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    CLR = 1'b0;

    do_if(32'h0);
    chk("t1_fetch_word", if_rdata, 32'hE3A01005);

    wr_log.delete();
    do_mem(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    exp_log[0] = 16'h10DE; exp_log[1] = 16'h11AD; exp_log[2] = 16'h12BE; exp_log[3] = 16'h13EF;
    chk("t2_write_beats", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ent = (i < wr_log.size()) ? wr_log[i] : 16'h0;
      chk("t2_write_beat", 32'(ent), 32'(exp_log[i]));
    end
    do_mem(1'b0, 2'b10, 32'h10, 32'h0);
    chk("t2_read_word", mem_rdata, 32'hDEADBEEF);
    do_mem(1'b0, 2'b00, 32'h13, 32'h0);
    chk("t2_read_byte", mem_rdata, 32'h000000EF);

    do_both(1'b0, 2'b01, 32'h12, 32'h0, 32'h10);
    chk("t3_halfword", mem_rdata, 32'h0000BEEF);

    wr_log.delete();
    do_mem(1'b0, 2'b10, 32'h11, 32'h0);
    do_mem(1'b0, 2'b11, 32'h20, 32'h0);
    do_mem(1'b0, 2'b10, 32'hFE, 32'h0);
    do_mem(1'b0, 2'b01, 32'h21, 32'h0);
    do_mem(1'b1, 2'b00, 32'h100, 32'h77);
    do_mem(1'b1, 2'b01, 32'hFF, 32'h1234);
    chk("t4_no_ram_writes", 32'(wr_log.size()), 32'd0);

    // Word write to 0x20 aborted by reset while beat 2 is on the bus.
    @(negedge CLK);
    mem_rw = 1'b1; mem_size = 2'b10; mem_addr = 32'h20; mem_wdata = 32'h11223344; mem_req = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t5_beat2_addr", 32'(ram_addr), 32'h22);
    CLR = 1'b1;
    #1;
    chk("t5_busy_after_clr", {31'd0, busy}, 32'd0);
    chk("t5_we_after_clr", {31'd0, ram_we}, 32'd0);
    mem_req = 1'b0;
    ref_mem[8'h20] = 8'h11;
    ref_mem[8'h21] = 8'h22;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);
    do_if(32'h20);

    do_mem(1'b1, 2'b00, 32'hFF, 32'h5A);
    do_if(32'hFD);
    chk("t6_wrap_byte", {24'd0, if_rdata[15:8]}, 32'h5A);

    for (int it = 0; it < 80; it++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 255);
        1: a = $urandom_range(248, 255);
        2: a = $urandom_range(256, 300);
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      wd = $urandom;
      case ($urandom_range(0, 2))
        0: do_mem(1'($urandom_range(0, 1)), sz, a, wd);
        1: do_if($urandom);
        default: do_both(1'($urandom_range(0, 1)), sz, a, wd, $urandom);
      endcase
    end

    repeat (3) @(negedge CLK);
    chk("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_final_image", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
